// File: rtl/rtc_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_spi_pkg
//  Description : Shared constants, FSM encoding and helpers for the RTC SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_spi_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_CTRL = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2
    } spi_state_t;

    // CTRL/STATUS bit positions
    localparam int C_BIT_CE     = 0;
    localparam int C_BIT_DIV_LO = 1;
    localparam int C_BIT_DIV_HI = 2;
    localparam int C_BIT_LSB    = 3;
    localparam int C_BIT_OVR    = 5;
    localparam int C_BIT_DONE   = 6;
    localparam int C_BIT_BUSY   = 7;

    // Reload value for the half-period counter: (1 << div) - 1.
    function automatic logic [2:0] half_period_m1(input logic [1:0] div);
        return 3'((4'd1 << div) - 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_spi_master_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shifter
//  Description : Mode-0 byte shift engine: FSM, half-period timer, TX/RX shifters.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_shifter
    import rtc_spi_pkg::*;
(
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic [1:0] div,
    input  logic       lsb_first,
    input  logic       miso,
    output logic       busy,
    output logic       done_pulse,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_data
);

    spi_state_t r_state;
    logic [2:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic       r_sck;
    logic       r_mosi;

    logic [2:0] w_reload;
    logic       w_tick;

    assign w_reload = half_period_m1(div);
    assign w_tick   = (r_cnt == 3'd0);

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_bit   <= 3'd0;
            r_tx    <= 8'h00;
            r_rx    <= 8'h00;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sck <= 1'b0;
                    if (start) begin
                        r_tx    <= tx_data;
                        r_mosi  <= lsb_first ? tx_data[0] : tx_data[7];
                        r_cnt   <= w_reload;
                        r_bit   <= 3'd0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sck   <= 1'b1;
                        r_cnt   <= w_reload;
                        r_rx    <= lsb_first ? {miso, r_rx[7:1]} : {r_rx[6:0], miso};
                        r_state <= HIGH;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                HIGH: begin
                    if (w_tick) begin
                        r_sck <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_state <= IDLE;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_cnt   <= w_reload;
                            r_state <= SETUP;
                            // Present the next bit as the falling edge of sck happens.
                            if (lsb_first) begin
                                r_tx   <= {1'b0, r_tx[7:1]};
                                r_mosi <= r_tx[1];
                            end else begin
                                r_tx   <= {r_tx[6:0], 1'b0};
                                r_mosi <= r_tx[6];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sck   <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    // Decoded from registered state so the status flag lands on the same edge busy drops.
    assign done_pulse = (r_state == HIGH) && w_tick && (r_bit == 3'd7);
    assign sck        = r_sck;
    assign mosi       = r_mosi;
    assign rx_data    = r_rx;

endmodule
`default_nettype wire

// File: rtl/rtc_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_spi_master
//  Description : CCTL-mapped SPI master for the cartridge RTC/expansion port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_spi_master
    import rtc_spi_pkg::*;
#(
    parameter logic [4:0] BASE = 5'b10111
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       cctl_n,
    input  logic       r_w,
    input  logic [7:0] cart_a,
    input  logic [7:0] cart_d_in,
    output logic [7:0] cart_d_out,
    output logic       cart_d_oe,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ce
);

    logic       w_sel;
    logic [2:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_start;
    logic       w_busy;
    logic       w_done_pulse;
    logic [7:0] w_rx;
    logic [7:0] w_status;
    logic [7:0] w_rdata;
    logic       w_unused;

    logic       r_ce;
    logic [1:0] r_div;
    logic       r_lsb_first;
    logic       r_done;
    logic       r_ovr;

    assign w_sel    = ~cctl_n & (cart_a[7:3] == BASE);
    assign w_off    = cart_a[2:0];
    assign w_wr     = w_sel & ~r_w;
    assign w_rd     = w_sel & r_w;
    assign w_start  = w_wr && (w_off == REG_DATA) && !w_busy;
    assign w_unused = &{1'b0, cart_d_in[7:4]};

    spi_shifter u_shifter (
        .phi2       (phi2),
        .rst_n      (rst_n),
        .start      (w_start),
        .tx_data    (cart_d_in),
        .div        (r_div),
        .lsb_first  (r_lsb_first),
        .miso       (miso),
        .busy       (w_busy),
        .done_pulse (w_done_pulse),
        .sck        (sck),
        .mosi       (mosi),
        .rx_data    (w_rx)
    );

    // Clears are written before sets so a coincident set wins.
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_ce        <= 1'b0;
            r_div       <= 2'd0;
            r_lsb_first <= 1'b1;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            if (w_rd && (w_off == REG_DATA)) r_done <= 1'b0;
            if (w_rd && (w_off == REG_CTRL)) r_ovr  <= 1'b0;
            if (w_done_pulse)                r_done <= 1'b1;
            if (w_wr && (w_off == REG_DATA) && w_busy) r_ovr <= 1'b1;
            if (w_wr && (w_off == REG_CTRL)) begin
                r_ce <= cart_d_in[C_BIT_CE];
                if (w_busy) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_div       <= cart_d_in[C_BIT_DIV_HI:C_BIT_DIV_LO];
                    r_lsb_first <= cart_d_in[C_BIT_LSB];
                end
            end
        end
    end

    always_comb begin
        w_status               = 8'h00;
        w_status[C_BIT_BUSY]   = w_busy;
        w_status[C_BIT_DONE]   = r_done;
        w_status[C_BIT_OVR]    = r_ovr;
        w_status[C_BIT_LSB]    = r_lsb_first;
        w_status[C_BIT_DIV_HI:C_BIT_DIV_LO] = r_div;
        w_status[C_BIT_CE]     = r_ce;
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            REG_DATA: w_rdata = w_rx;
            REG_CTRL: w_rdata = w_status;
            default:  w_rdata = 8'h00;
        endcase
    end

    assign cart_d_out = w_rdata;
    assign cart_d_oe  = w_sel & r_w & phi2;
    assign ce         = r_ce;

endmodule
`default_nettype wire

// File: tb/tb_rtc_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_spi_master
//  Description : Self-checking bench for rtc_spi_master with a timeline-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_spi_master;

    logic       phi2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cctl_n = 1'b1;
    logic       r_w = 1'b1;
    logic [7:0] cart_a = 8'h00;
    logic [7:0] cart_d_in = 8'h00;
    logic [7:0] cart_d_out;
    logic       cart_d_oe;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       ce;
    logic       miso_drv = 1'b0;
    logic       loop_en = 1'b0;

    int checks = 0;
    int passed = 0;

    logic [7:0] rd_d;
    logic       rd_oe_lo;
    logic       rd_oe_hi;

    assign miso = loop_en ? mosi : miso_drv;

    rtc_spi_master #(.BASE(5'b10111)) dut (
        .phi2       (phi2),
        .rst_n      (rst_n),
        .cctl_n     (cctl_n),
        .r_w        (r_w),
        .cart_a     (cart_a),
        .cart_d_in  (cart_d_in),
        .cart_d_out (cart_d_out),
        .cart_d_oe  (cart_d_oe),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .ce         (ce)
    );

    always #5 phi2 = ~phi2;

    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        @(negedge phi2);
        cctl_n = 1'b0; r_w = 1'b0; cart_a = {5'b10111, off}; cart_d_in = d;
        @(posedge phi2);
        #1;
        cctl_n = 1'b1; r_w = 1'b1;
    endtask

    // Data sampled late in the low phase (before the side-effect edge), oe in both phases.
    task automatic bus_read(input logic [7:0] a);
        @(negedge phi2);
        cctl_n = 1'b0; r_w = 1'b1; cart_a = a;
        #4;
        rd_d = cart_d_out;
        rd_oe_lo = cart_d_oe;
        @(posedge phi2);
        #1;
        rd_oe_hi = cart_d_oe;
        cctl_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge phi2);
        #2 rst_n = 1'b1;
        checks++; if (sck !== 1'b0) $display("FAIL reset_sck got=%b exp=0", sck); else passed++;
        checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", mosi); else passed++;
        checks++; if (ce !== 1'b0) $display("FAIL reset_ce got=%b exp=0", ce); else passed++;
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'h08) $display("FAIL reset_status got=%h exp=08", rd_d); else passed++;
        bus_read(8'hB8);
        checks++; if (rd_d !== 8'h00) $display("FAIL reset_rx got=%h exp=00", rd_d); else passed++;
    endtask

    // mode 0: random miso, 1: loopback, 2: miso tied high. rd=0 leaves done set.
    task automatic test_xfer(input logic [7:0] ctrl, input logic [7:0] tx, input int mode, input bit rd);
        int h;
        int n_cyc;
        int bi;
        logic exp_sck;
        logic exp_mosi;
        logic [7:0] exp_rx;
        logic m [0:160];
        h = 1 << ctrl[2:1];
        n_cyc = 16 * h;
        loop_en = (mode == 1);
        miso_drv = 1'b0;
        bus_write(3'd1, ctrl);
        bus_write(3'd0, tx);
        cctl_n = 1'b0; r_w = 1'b1; cart_a = 8'hB9;
        for (int c = 0; c <= n_cyc; c++) begin
            @(negedge phi2);
            #1;
            exp_sck = (c < n_cyc) && (((c / h) % 2) == 1);
            checks++; if (sck !== exp_sck) $display("FAIL xfer_sck c=%0d got=%b exp=%b", c, sck, exp_sck); else passed++;
            checks++; if (cart_d_out[7] !== (c < n_cyc)) $display("FAIL xfer_busy c=%0d got=%b exp=%b", c, cart_d_out[7], (c < n_cyc)); else passed++;
            if (c < n_cyc) begin
                bi = c / (2 * h);
                exp_mosi = ctrl[3] ? tx[bi] : tx[7 - bi];
                checks++; if (mosi !== exp_mosi) $display("FAIL xfer_mosi c=%0d got=%b exp=%b", c, mosi, exp_mosi); else passed++;
            end else begin
                checks++;
                if (cart_d_out !== {4'b0100, ctrl[3:0]}) $display("FAIL xfer_end_status got=%h exp=%h", cart_d_out, {4'b0100, ctrl[3:0]});
                else passed++;
            end
            miso_drv = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            m[c + 1] = miso_drv;
        end
        cctl_n = 1'b1;
        checks++; if (ce !== ctrl[0]) $display("FAIL xfer_ce got=%b exp=%b", ce, ctrl[0]); else passed++;
        exp_rx = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (ctrl[3]) exp_rx[b] = m[(2 * b + 1) * h];
            else         exp_rx[7 - b] = m[(2 * b + 1) * h];
        end
        if (mode == 1) exp_rx = tx;
        if (rd) begin
            bus_read(8'hB8);
            checks++; if (rd_d !== exp_rx) $display("FAIL xfer_rx got=%h exp=%h", rd_d, exp_rx); else passed++;
            bus_read(8'hB9);
            checks++;
            if (rd_d !== {4'b0000, ctrl[3:0]}) $display("FAIL xfer_done_clear got=%h exp=%h", rd_d, {4'b0000, ctrl[3:0]});
            else passed++;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            test_xfer(8'($urandom) & 8'h0F, 8'($urandom), 0, 1'b1);
        end
    endtask

    task automatic test_overrun;
        int i;
        test_xfer(8'h00, 8'h5A, 1, 1'b0);
        loop_en = 1'b1;
        bus_write(3'd0, 8'hC3);
        bus_write(3'd0, 8'hFF);
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'hE0) $display("FAIL ovr_status got=%h exp=E0", rd_d); else passed++;
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'hC0) $display("FAIL ovr_cleared got=%h exp=C0", rd_d); else passed++;
        bus_write(3'd1, 8'h0F);
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'hE1) $display("FAIL ctrl_busy_write got=%h exp=E1", rd_d); else passed++;
        for (i = 0; i < 40; i++) begin
            bus_read(8'hB9);
            if (rd_d[7] == 1'b0) break;
        end
        checks++; if (i !== 11) $display("FAIL ovr_busy_clear got=%0d exp=11", i); else passed++;
        bus_read(8'hB8);
        checks++; if (rd_d !== 8'hC3) $display("FAIL ovr_rx got=%h exp=C3", rd_d); else passed++;
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'h01) $display("FAIL ovr_final_status got=%h exp=01", rd_d); else passed++;
    endtask

    task automatic test_edge_write;
        loop_en = 1'b1;
        bus_write(3'd1, 8'h00);
        bus_write(3'd0, 8'h96);
        repeat (15) @(posedge phi2);
        bus_write(3'd0, 8'h11);
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'h60) $display("FAIL edge_write_status got=%h exp=60", rd_d); else passed++;
        repeat (3) @(posedge phi2);
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'h40) $display("FAIL edge_write_idle got=%h exp=40", rd_d); else passed++;
        bus_read(8'hB8);
        checks++; if (rd_d !== 8'h96) $display("FAIL edge_write_rx got=%h exp=96", rd_d); else passed++;
    endtask

    task automatic test_reset_mid;
        test_xfer(8'h00, 8'h42, 0, 1'b0);
        loop_en = 1'b0;
        miso_drv = 1'b1;
        bus_write(3'd0, 8'h81);
        repeat (9) @(posedge phi2);
        #2;
        checks++; if (sck !== 1'b1) $display("FAIL rst_mid_pre_sck got=%b exp=1", sck); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (sck !== 1'b0) $display("FAIL rst_mid_sck got=%b exp=0", sck); else passed++;
        checks++; if (mosi !== 1'b0) $display("FAIL rst_mid_mosi got=%b exp=0", mosi); else passed++;
        cctl_n = 1'b0; r_w = 1'b1; cart_a = 8'hB9;
        #1;
        checks++; if (cart_d_out !== 8'h08) $display("FAIL rst_mid_status got=%h exp=08", cart_d_out); else passed++;
        cart_a = 8'hB8;
        #1;
        checks++; if (cart_d_out !== 8'h00) $display("FAIL rst_mid_rx got=%h exp=00", cart_d_out); else passed++;
        cctl_n = 1'b1;
        @(negedge phi2);
        rst_n = 1'b1;
    endtask

    task automatic test_addr;
        logic [7:0] a;
        for (int off = 2; off < 8; off++) bus_write(3'(off), 8'hFF);
        bus_read(8'hB9);
        checks++; if (rd_d !== 8'h08) $display("FAIL addr_ignored_status got=%h exp=08", rd_d); else passed++;
        bus_read(8'hB8);
        checks++; if (rd_d !== 8'h00) $display("FAIL addr_ignored_rx got=%h exp=00", rd_d); else passed++;
        for (int off = 2; off < 8; off++) begin
            a = 8'hB8 + 8'(off);
            bus_read(a);
            checks++; if (rd_d !== 8'h00) $display("FAIL addr_read a=%h got=%h exp=00", a, rd_d); else passed++;
            checks++; if (rd_oe_hi !== 1'b1) $display("FAIL addr_oe_hi a=%h got=%b exp=1", a, rd_oe_hi); else passed++;
            checks++; if (rd_oe_lo !== 1'b0) $display("FAIL addr_oe_lo a=%h got=%b exp=0", a, rd_oe_lo); else passed++;
        end
        bus_read(8'hC0);
        checks++; if (rd_oe_hi !== 1'b0) $display("FAIL addr_out_c0 got=%b exp=0", rd_oe_hi); else passed++;
        bus_read(8'hB7);
        checks++; if (rd_oe_hi !== 1'b0) $display("FAIL addr_out_b7 got=%b exp=0", rd_oe_hi); else passed++;
    endtask

    initial begin
        test_reset();
        test_xfer(8'h01, 8'hA5, 1, 1'b1);
        test_xfer(8'h07, 8'h3C, 2, 1'b1);
        test_random();
        test_overrun();
        test_edge_write();
        test_reset_mid();
        test_addr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
